// File: rtl/axi_alu_bank.sv
// AXI4-Lite register bank of independent ALU channels: two operands, a control
// register and a live read-only result per channel, with byte-lane writes.
`timescale 1ns/1ps

module axi_alu_bank #(
  parameter int NUM_CHANNELS     = 4,
  parameter int S_AXI_DATA_WIDTH = 32,
  parameter int S_AXI_ADDR_WIDTH = 6
) (
  input  logic                          AXI_ACLK,
  input  logic                          AXI_ARESETN,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  input  logic [2:0]                    S_AXI_ARPROT,
  output logic [S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY
);
  localparam int DW = S_AXI_DATA_WIDTH;
  localparam int AW = S_AXI_ADDR_WIDTH;
  localparam int SW = DW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_EXEC, WR_RESP} wrState_t;
  typedef enum logic [1:0] {RD_IDLE, RD_LOOKUP, RD_RESP} rdState_t;

  function automatic logic isMapped(input logic [AW-1:0] a);
    return 32'(a) < 32'(NUM_CHANNELS * 16);
  endfunction

  function automatic logic isChannel(input logic [AW-1:0] a, input int c);
    return (32'(a) >> 4) == 32'(c);
  endfunction

  function automatic logic [DW-1:0] applyStrb(input logic [DW-1:0] oldVal,
                                               input logic [DW-1:0] newVal,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] v;
    v = oldVal;
    for (int b = 0; b < SW; b++)
      if (strb[b]) v[b*8 +: 8] = newVal[b*8 +: 8];
    return v;
  endfunction

  logic [DW-1:0] r_op1  [NUM_CHANNELS];
  logic [DW-1:0] r_op2  [NUM_CHANNELS];
  logic [2:0]    r_mode [NUM_CHANNELS];
  logic [DW-1:0] w_result [NUM_CHANNELS];
  logic          w_flag   [NUM_CHANNELS];

  wrState_t r_wrState, w_wrNext;
  rdState_t r_rdState, w_rdNext;

  logic          r_awReady, r_wReady, r_bValid, r_arReady, r_rValid;
  logic [AW-1:0] r_awAddr, r_arAddr;
  logic [DW-1:0] r_wData, r_rData;
  logic [SW-1:0] r_wStrb;
  logic [1:0]    r_bResp, r_rResp;

  logic          w_awFire, w_wFire, w_arFire;
  logic          w_commit, w_bDone, w_rDone, w_wrOk;
  logic [AW-1:0] w_wrAddr;
  logic [DW-1:0] w_wrData, w_rdData;
  logic [SW-1:0] w_wrStrb;
  logic [1:0]    w_rdResp;
  logic          w_unused;

  assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_alu
    logic [DW:0]   w_sum, w_diff;
    logic [DW-1:0] w_res;
    logic          w_flg;
    assign w_sum  = {1'b0, r_op1[c]} + {1'b0, r_op2[c]};
    assign w_diff = {1'b0, r_op1[c]} - {1'b0, r_op2[c]};
    always_comb begin
      w_res = '0;
      w_flg = 1'b0;
      case (r_mode[c])
        3'd0: begin w_res = w_sum[DW-1:0];  w_flg = w_sum[DW];  end
        3'd1: begin w_res = w_diff[DW-1:0]; w_flg = w_diff[DW]; end
        3'd2: w_res = r_op1[c] & r_op2[c];
        3'd3: w_res = r_op1[c] | r_op2[c];
        3'd4: w_res = r_op1[c] ^ r_op2[c];
        default: ;
      endcase
    end
    assign w_result[c] = w_res;
    assign w_flag[c]   = w_flg;
  end

  // A half of the write that already handshook is taken from its holding register.
  assign w_awFire = S_AXI_AWVALID && r_awReady;
  assign w_wFire  = S_AXI_WVALID && r_wReady;
  assign w_arFire = S_AXI_ARVALID && r_arReady;
  assign w_wrAddr = r_awReady ? S_AXI_AWADDR : r_awAddr;
  assign w_wrData = r_wReady  ? S_AXI_WDATA  : r_wData;
  assign w_wrStrb = r_wReady  ? S_AXI_WSTRB  : r_wStrb;
  assign w_wrOk   = isMapped(w_wrAddr) && (w_wrAddr[3:2] != 2'd2);

  always_comb begin
    w_wrNext = r_wrState;
    w_commit = 1'b0;
    w_bDone  = 1'b0;
    case (r_wrState)
      WR_IDLE: if ((!r_awReady || w_awFire) && (!r_wReady || w_wFire)) begin
        w_commit = 1'b1;
        w_wrNext = WR_EXEC;
      end
      WR_EXEC: w_wrNext = WR_RESP;
      WR_RESP: if (S_AXI_BREADY) begin
        w_bDone  = 1'b1;
        w_wrNext = WR_IDLE;
      end
      default: w_wrNext = WR_IDLE;
    endcase
  end

  always_comb begin
    w_rdNext = r_rdState;
    w_rDone  = 1'b0;
    case (r_rdState)
      RD_IDLE:   if (w_arFire) w_rdNext = RD_LOOKUP;
      RD_LOOKUP: w_rdNext = RD_RESP;
      RD_RESP:   if (S_AXI_RREADY) begin
        w_rDone  = 1'b1;
        w_rdNext = RD_IDLE;
      end
      default: w_rdNext = RD_IDLE;
    endcase
  end

  always_comb begin
    w_rdData = '0;
    w_rdResp = RESP_SLVERR;
    if (isMapped(r_arAddr)) begin
      w_rdResp = RESP_OKAY;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (isChannel(r_arAddr, c)) begin
          case (r_arAddr[3:2])
            2'd0: w_rdData = r_op1[c];
            2'd1: w_rdData = r_op2[c];
            2'd2: w_rdData = w_result[c];
            default: begin
              w_rdData[2:0] = r_mode[c];
              w_rdData[16]  = w_flag[c];
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_wrState <= WR_IDLE;
      r_rdState <= RD_IDLE;
    end else begin
      r_wrState <= w_wrNext;
      r_rdState <= w_rdNext;
    end
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      r_awReady <= 1'b1;
      r_wReady  <= 1'b1;
      r_awAddr  <= '0;
      r_wData   <= '0;
      r_wStrb   <= '0;
      r_bValid  <= 1'b0;
      r_bResp   <= RESP_OKAY;
      r_arReady <= 1'b1;
      r_arAddr  <= '0;
      r_rValid  <= 1'b0;
      r_rData   <= '0;
      r_rResp   <= RESP_OKAY;
    end else begin
      if (w_awFire) begin
        r_awReady <= 1'b0;
        r_awAddr  <= S_AXI_AWADDR;
      end
      if (w_wFire) begin
        r_wReady <= 1'b0;
        r_wData  <= S_AXI_WDATA;
        r_wStrb  <= S_AXI_WSTRB;
      end
      if (w_commit) r_bResp <= w_wrOk ? RESP_OKAY : RESP_SLVERR;
      if (r_wrState == WR_EXEC) r_bValid <= 1'b1;
      if (w_bDone) begin
        r_bValid  <= 1'b0;
        r_awReady <= 1'b1;
        r_wReady  <= 1'b1;
      end
      if (w_arFire) begin
        r_arReady <= 1'b0;
        r_arAddr  <= S_AXI_ARADDR;
      end
      if (r_rdState == RD_LOOKUP) begin
        r_rValid <= 1'b1;
        r_rData  <= w_rdData;
        r_rResp  <= w_rdResp;
      end
      if (w_rDone) begin
        r_rValid  <= 1'b0;
        r_arReady <= 1'b1;
      end
    end
  end

  // Only CTRL bits [2:0] are storage; FLAG and the rest are produced on read.
  always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
    if (!AXI_ARESETN) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        r_op1[c]  <= '0;
        r_op2[c]  <= '0;
        r_mode[c] <= '0;
      end
    end else if (w_commit && w_wrOk) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (isChannel(w_wrAddr, c)) begin
          case (w_wrAddr[3:2])
            2'd0: r_op1[c] <= applyStrb(r_op1[c], w_wrData, w_wrStrb);
            2'd1: r_op2[c] <= applyStrb(r_op2[c], w_wrData, w_wrStrb);
            2'd3: if (w_wrStrb[0]) r_mode[c] <= w_wrData[2:0];
            default: ;
          endcase
        end
      end
    end
  end

  assign S_AXI_AWREADY = r_awReady;
  assign S_AXI_WREADY  = r_wReady;
  assign S_AXI_BVALID  = r_bValid;
  assign S_AXI_BRESP   = r_bResp;
  assign S_AXI_ARREADY = r_arReady;
  assign S_AXI_RVALID  = r_rValid;
  assign S_AXI_RDATA   = r_rData;
  assign S_AXI_RRESP   = r_rResp;

endmodule

// File: tb/tb_axi_alu_bank.sv
// Directed bench for axi_alu_bank with three channels: register access, ALU modes,
// byte lanes, decoupled AW/W, error responses, read/write collision and async reset.
`timescale 1ns/1ps

module tb_axi_alu_bank;
  localparam int NCH = 3;
  localparam int DW  = 32;
  localparam int AW  = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   S_AXI_AWADDR;
  logic            S_AXI_AWVALID, S_AXI_AWREADY;
  logic [2:0]      S_AXI_AWPROT;
  logic [DW-1:0]   S_AXI_WDATA;
  logic [DW/8-1:0] S_AXI_WSTRB;
  logic            S_AXI_WVALID, S_AXI_WREADY;
  logic [1:0]      S_AXI_BRESP;
  logic            S_AXI_BVALID, S_AXI_BREADY;
  logic [AW-1:0]   S_AXI_ARADDR;
  logic            S_AXI_ARVALID, S_AXI_ARREADY;
  logic [2:0]      S_AXI_ARPROT;
  logic [DW-1:0]   S_AXI_RDATA;
  logic [1:0]      S_AXI_RRESP;
  logic            S_AXI_RVALID, S_AXI_RREADY;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_alu_bank #(
    .NUM_CHANNELS(NCH), .S_AXI_DATA_WIDTH(DW), .S_AXI_ADDR_WIDTH(AW)
  ) dut (
    .AXI_ACLK(clk), .AXI_ARESETN(rst_n),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                            input logic [DW/8-1:0] strb, output logic [1:0] resp);
    bit awDone, wDone, awHs, wHs, bSeen;
    awDone = 0; wDone = 0; bSeen = 0;
    resp = 2'bxx;
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    for (int n = 0; n < 20 && !(awDone && wDone); n++) begin
      awHs = S_AXI_AWVALID && S_AXI_AWREADY;
      wHs  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge clk); #1;
      if (awHs) begin S_AXI_AWVALID = 1'b0; awDone = 1; end
      if (wHs)  begin S_AXI_WVALID  = 1'b0; wDone  = 1; end
    end
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    S_AXI_BREADY = 1'b1;
    for (int n = 0; n < 20 && !bSeen; n++) begin
      if (S_AXI_BVALID) begin
        resp = S_AXI_BRESP;
        bSeen = 1;
      end
      @(posedge clk); #1;
    end
    S_AXI_BREADY = 1'b0;
  endtask

  task automatic applyRead(input logic [AW-1:0] addr, output logic [DW-1:0] data,
                           output logic [1:0] resp, output int lat);
    bit hs;
    hs = 0; lat = -1;
    data = 'x; resp = 2'bxx;
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    for (int n = 0; n < 20 && !hs; n++) begin
      hs = S_AXI_ARREADY;
      @(posedge clk); #1;
    end
    S_AXI_ARVALID = 1'b0;
    if (hs) begin
      if (S_AXI_RVALID) lat = 0;
      for (int n = 1; n <= 20 && lat < 0; n++) begin
        @(posedge clk); #1;
        if (S_AXI_RVALID) lat = n;
      end
      if (lat >= 0) begin
        data = S_AXI_RDATA; resp = S_AXI_RRESP;
        S_AXI_RREADY = 1'b1;
        @(posedge clk); #1;
        S_AXI_RREADY = 1'b0;
      end
    end
  endtask

  task automatic wrCheck(input string tag, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DW/8-1:0] strb, input logic [1:0] expResp);
    logic [1:0] resp;
    applyWrite(addr, data, strb, resp);
    checkOutput({tag, "_bresp"}, 64'(resp), 64'(expResp));
  endtask

  task automatic rdCheck(input string tag, input logic [AW-1:0] addr,
                         input logic [DW-1:0] expData, input logic [1:0] expResp);
    logic [DW-1:0] data;
    logic [1:0]    resp;
    int            lat;
    applyRead(addr, data, resp, lat);
    checkOutput({tag, "_rdata"}, 64'(data), 64'(expData));
    checkOutput({tag, "_rresp"}, 64'(resp), 64'(expResp));
    checkOutput({tag, "_latency"}, 64'(lat), 64'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWVALID = 1'b0; S_AXI_AWPROT = '0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARVALID = 1'b0; S_AXI_ARPROT = '0; S_AXI_RREADY = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] reset state");
    checkOutput("reset_handshakes", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                     S_AXI_BVALID, S_AXI_RVALID}, 5'b11100);
    checkOutput("reset_resp_data", {S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 64'h0);
    rdCheck("ch0_op1_reset", 6'h00, 32'h0000_0000, 2'b00);

    $display("[TB] channel 1 add/sub");
    wrCheck("ch1_op1_wr", 6'h10, 32'hFFFF_FFF0, 4'hF, 2'b00);
    wrCheck("ch1_op2_wr", 6'h14, 32'h0000_0020, 4'hF, 2'b00);
    wrCheck("ch1_ctrl_add", 6'h1C, 32'h0000_0000, 4'hF, 2'b00);
    rdCheck("ch1_add_result", 6'h18, 32'h0000_0010, 2'b00);
    rdCheck("ch1_add_carry", 6'h1C, 32'h0001_0000, 2'b00);
    wrCheck("ch1_ctrl_sub", 6'h1C, 32'h0000_0001, 4'hF, 2'b00);
    rdCheck("ch1_sub_result", 6'h18, 32'hFFFF_FFD0, 2'b00);
    rdCheck("ch1_sub_noborrow", 6'h1C, 32'h0000_0001, 2'b00);
    wrCheck("ch1_strb0_wr", 6'h14, 32'hDEAD_BEEF, 4'h0, 2'b00);
    rdCheck("ch1_strb0_unchanged", 6'h14, 32'h0000_0020, 2'b00);

    $display("[TB] channel 2 byte lanes and xor");
    wrCheck("ch2_op1_full", 6'h20, 32'h1234_5678, 4'hF, 2'b00);
    wrCheck("ch2_op1_lanes", 6'h20, 32'hAABB_CCDD, 4'b0101, 2'b00);
    rdCheck("ch2_op1_merged", 6'h20, 32'h12BB_56DD, 2'b00);
    wrCheck("ch2_op2_wr", 6'h24, 32'h0F0F_0F0F, 4'hF, 2'b00);
    wrCheck("ch2_ctrl_xor", 6'h2C, 32'h0000_0004, 4'hF, 2'b00);
    rdCheck("ch2_xor_result", 6'h28, 32'h1DB4_59D2, 2'b00);

    $display("[TB] W ahead of AW, slow BREADY");
    S_AXI_AWADDR = 6'h04; S_AXI_WDATA = 32'hCAFE_F00D; S_AXI_WSTRB = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_WVALID = 1'b0;
    checkOutput("early_w_ready_drop", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b100);
    @(posedge clk); #1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0;
    checkOutput("early_w_commit_edge", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput("early_w_bvalid_hold", {S_AXI_BVALID, S_AXI_BRESP}, 3'b100);
    end
    S_AXI_BREADY = 1'b1;
    @(posedge clk); #1;
    S_AXI_BREADY = 1'b0;
    checkOutput("early_w_ready_return", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID}, 3'b110);
    rdCheck("early_w_committed", 6'h04, 32'hCAFE_F00D, 2'b00);

    $display("[TB] error responses");
    wrCheck("wr_result_slverr", 6'h08, 32'h0000_0055, 4'hF, 2'b10);
    rdCheck("ch0_result_unchanged", 6'h08, 32'hCAFE_F00D, 2'b00);
    wrCheck("wr_unmapped_slverr", 6'h3C, 32'h0000_0003, 4'hF, 2'b10);
    rdCheck("ch2_ctrl_unchanged", 6'h2C, 32'h0000_0004, 2'b00);
    rdCheck("rd_unmapped_slverr", 6'h30, 32'h0000_0000, 2'b10);

    $display("[TB] read/write collision, then reset with both responses pending");
    S_AXI_ARADDR = 6'h10; S_AXI_ARVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR = 6'h10; S_AXI_WDATA = 32'h0000_0001; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    @(posedge clk); #1;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    checkOutput("collision_rvalid", {S_AXI_RVALID, S_AXI_BVALID}, 2'b10);
    checkOutput("collision_pre_write", 64'(S_AXI_RDATA), 64'hFFFF_FFF0);
    @(posedge clk); #1;
    checkOutput("pending_both_valid", {S_AXI_BVALID, S_AXI_RVALID, S_AXI_BRESP}, 4'b1100);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_reset_drop", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                     S_AXI_BVALID, S_AXI_RVALID}, 5'b11100);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("after_release_handshakes", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY,
                                             S_AXI_BVALID, S_AXI_RVALID}, 5'b11100);
    rdCheck("reset_clears_ch1_op1", 6'h10, 32'h0000_0000, 2'b00);
    rdCheck("reset_clears_ch0_op2", 6'h04, 32'h0000_0000, 2'b00);
    rdCheck("reset_clears_ch2_ctrl", 6'h2C, 32'h0000_0000, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
